// File: rtl/hex_readback.sv
// Seven-segment readback: synchronizes three active-low HEX buses, debounces each
// digit, decodes accepted glyphs and presents change events on a valid/ready port.
module hex_readback #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [6:0]  HEX0,
  input  logic [6:0]  HEX1,
  input  logic [6:0]  HEX3,
  input  logic        OUT_READY,
  output logic        OUT_VALID,
  output logic [11:0] DIGITS,
  output logic [2:0]  BLANK,
  output logic [2:0]  INVALID,
  output logic        OVERRUN,
  output logic [15:0] CHANGE_COUNT
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state;
  logic [2:0][6:0]   hex_in;
  logic [2:0][6:0]   sync1;
  logic [2:0][6:0]   sync2;
  logic [2:0][6:0]   prev;
  logic [2:0][6:0]   last;
  logic [2:0][3:0]   cnt;
  logic [2:0][6:0]   snap;
  logic [2:0]        accept;
  logic              event_hit;
  logic [11:0]       snap_digits;
  logic [2:0]        snap_blank;
  logic [2:0]        snap_invalid;
  logic [5:0]        dec;

  // Returns {blank, invalid, nibble}.
  function automatic logic [5:0] decode_seg(input logic [6:0] seg);
    logic [5:0] r;
    r = 6'b010000;
    case (seg)
      7'h40: r = {2'b00, 4'h0};
      7'h79: r = {2'b00, 4'h1};
      7'h24: r = {2'b00, 4'h2};
      7'h30: r = {2'b00, 4'h3};
      7'h19: r = {2'b00, 4'h4};
      7'h12: r = {2'b00, 4'h5};
      7'h02: r = {2'b00, 4'h6};
      7'h78: r = {2'b00, 4'h7};
      7'h00: r = {2'b00, 4'h8};
      7'h10: r = {2'b00, 4'h9};
      7'h08: r = {2'b00, 4'hA};
      7'h03: r = {2'b00, 4'hB};
      7'h46: r = {2'b00, 4'hC};
      7'h21: r = {2'b00, 4'hD};
      7'h06: r = {2'b00, 4'hE};
      7'h0E: r = {2'b00, 4'hF};
      7'h7F: r = 6'b100000;
      default: r = 6'b010000;
    endcase
    return r;
  endfunction

  assign hex_in = {HEX3, HEX1, HEX0};

  // prev is the synchronized pattern one cycle older; the counter measures how long it has held.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= {3{SEG_BLANK}};
      sync2 <= {3{SEG_BLANK}};
      prev  <= {3{SEG_BLANK}};
      last  <= {3{SEG_BLANK}};
      cnt   <= '0;
    end else begin
      sync1 <= hex_in;
      sync2 <= sync1;
      prev  <= sync2;
      last  <= snap;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] != prev[i])
          cnt[i] <= 4'd1;
        else if (cnt[i] != STABLE)
          cnt[i] <= cnt[i] + 4'd1;
      end
    end
  end

  always_comb begin
    accept       = '0;
    snap         = last;
    snap_digits  = '0;
    snap_blank   = '0;
    snap_invalid = '0;
    dec          = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (cnt[i] == STABLE && prev[i] != last[i]) begin
        accept[i] = 1'b1;
        snap[i]   = prev[i];
      end
      dec                  = decode_seg(snap[i]);
      snap_blank[i]        = dec[5];
      snap_invalid[i]      = dec[4];
      snap_digits[4*i +: 4] = dec[3:0];
    end
    event_hit = |accept;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      OUT_VALID    <= 1'b0;
      DIGITS       <= '0;
      BLANK        <= '1;
      INVALID      <= '0;
      OVERRUN      <= 1'b0;
      CHANGE_COUNT <= '0;
    end else begin
      if (event_hit) begin
        DIGITS  <= snap_digits;
        BLANK   <= snap_blank;
        INVALID <= snap_invalid;
        if (CHANGE_COUNT != '1)
          CHANGE_COUNT <= CHANGE_COUNT + 16'd1;
      end
      case (state)
        IDLE: begin
          if (event_hit) begin
            state     <= PEND;
            OUT_VALID <= 1'b1;
          end
        end
        PEND: begin
          if (event_hit) begin
            if (!OUT_READY)
              OVERRUN <= 1'b1;
          end else if (OUT_READY) begin
            state     <= IDLE;
            OUT_VALID <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          OUT_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hex_readback.md
HEX_READBACK -- requirements
Module: hex_readback

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, sets the consecutive cycles a synchronized pattern must hold before acceptance; legal range is 1..15.
REQ-002 CLOCK_50  input  1  single clock; all state updates on its rising edge.
REQ-003 RESET_N  input  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
REQ-004 HEX0  input  7  digit 0 segment bus, active-low, bit0=a .. bit6=g.
REQ-005 HEX1  input  7  digit 1 segment bus, same encoding.
REQ-006 HEX3  input  7  digit 2 segment bus, same encoding.
REQ-007 OUT_READY  input  1  consumer accepts the current event.
REQ-008 OUT_VALID  output  1  event pending on DIGITS/BLANK/INVALID.
REQ-009 DIGITS  output  12  decoded nibbles {HEX3, HEX1, HEX0}.
REQ-010 BLANK  output  3  per-digit flag, pattern 7'h7F, ordered {HEX3, HEX1, HEX0}.
REQ-011 INVALID  output  3  per-digit flag, pattern neither a hex glyph nor blank.
REQ-012 OVERRUN  output  1  sticky flag, an unconsumed event was overwritten.
REQ-013 CHANGE_COUNT  output  16  count of accepted events, saturating.

Function
REQ-014 Each HEX bus SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Decode table, active-low gfedcba: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex), blank=7F.
REQ-016 Blank or invalid digits SHALL decode to nibble 0 and raise the matching BLANK/INVALID bit; a valid glyph clears both bits.
REQ-017 Per-digit stability counter: reset to 1 when the synchronized pattern differs from the previous cycle's, else increment, saturating at STABLE_CYCLES.
REQ-018 A digit's pattern SHALL be accepted on the cycle its counter reaches STABLE_CYCLES while the pattern differs from that digit's last accepted pattern.
REQ-019 Acceptances of one or more digits in the same cycle SHALL form exactly one event.
REQ-020 Latency from a HEX input change (held stable) to OUT_VALID high SHALL be exactly STABLE_CYCLES+3 cycles; 7 at default.
REQ-021 Glitches shorter than STABLE_CYCLES synchronized cycles SHALL produce no event and no output change.
REQ-022 Output FSM has two states, IDLE and PEND; OUT_VALID=1 only in PEND.
REQ-023 IDLE + event -> PEND, with outputs loaded from the full accepted snapshot of all three digits.
REQ-024 PEND + OUT_READY=1 with no event -> IDLE; outputs hold their values.
REQ-025 PEND + OUT_READY=0 with no event -> PEND; DIGITS/BLANK/INVALID SHALL stay unchanged.
REQ-026 PEND + OUT_READY=1 + new event in the same cycle -> PEND with the new snapshot; OVERRUN unchanged.
REQ-027 PEND + OUT_READY=0 + new event -> PEND with the new snapshot replacing the old; OVERRUN set to 1.
REQ-028 OVERRUN SHALL clear only on reset.
REQ-029 CHANGE_COUNT SHALL increment by 1 per event, including overwritten ones, and saturate at 16'hFFFF.

Reset
REQ-030 While RESET_N=0 the following SHALL hold: synchronizer flops and last-accepted patterns = 7'h7F; stability counters = 0; FSM = IDLE.
REQ-031 Output values in reset SHALL be: OUT_VALID=0, DIGITS=0, BLANK=3'b111, INVALID=0, OVERRUN=0, CHANGE_COUNT=0.
REQ-032 After RESET_N deasserts with all HEX inputs at 7'h7F, no event SHALL occur.
REQ-033 Reset asserted mid-PEND SHALL drop OUT_VALID immediately; no event is emitted for a pattern still in counting.

Verification
REQ-034 Reset, HEX0=40, HEX1=79, HEX3=24 held, OUT_READY=1 -> OUT_VALID pulses 1 cycle, 7 cycles later; DIGITS=12'h210, BLANK=0, INVALID=0, CHANGE_COUNT=1.
REQ-035 HEX0 glitched to 79 for 2 cycles, then back to 40 -> no OUT_VALID; CHANGE_COUNT unchanged.
REQ-036 HEX1=7F, HEX0=55 -> BLANK=3'b010, INVALID=3'b001, DIGITS nibbles 1 and 0 = 0.
REQ-037 OUT_READY=0; HEX0 steps 40 to 79 to 24, each held 10 cycles -> OUT_VALID stays 1; DIGITS[3:0]=2; OVERRUN=1; CHANGE_COUNT=3.
REQ-038 OUT_READY=1 in the same cycle as a new acceptance -> OUT_VALID stays 1 with the new data; OVERRUN stays 0.
REQ-039 Force 65536 events, then one more -> CHANGE_COUNT=FFFF; RESET_N pulsed low mid-PEND -> all outputs return to the REQ-031 values asynchronously.
